// File: rtl/lab1_gate_tester.sv
// Stimulus/response checker for the lab1 NAND-built AND/OR/NOT gate trio.
// Walks (A,B) through 00,01,10,11, settles, samples, and tallies mismatches.
module lab1_gate_tester #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             inAND,
    input  logic             inOR,
    input  logic             inNOT,
    output logic             outA,
    output logic             outB,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic             first_fail_valid
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned VEC_W = 2;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC  = VEC_W'(3);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [VEC_W-1:0]  vec;
    logic [VEC_W-1:0]  vecNext;
    logic [CNT_W-1:0]  waitCnt;
    logic [CNT_W-1:0]  waitCntNext;
    logic [ERR_W-1:0]  errCountNext;
    logic [VEC_W-1:0]  firstFailVecNext;
    logic              firstFailValidNext;

    logic stimA;
    logic stimB;
    logic mismatch;

    // Golden comparison against the vector currently applied to the gates
    assign stimA    = vec[1];
    assign stimB    = vec[0];
    assign mismatch = (inAND != (stimA & stimB)) |
                      (inOR  != (stimA | stimB)) |
                      (inNOT != ~stimA);

    // Outputs decode registered state only; IDLE parks the stimulus at 00
    assign outA = (state != IDLE) & stimA;
    assign outB = (state != IDLE) & stimB;
    assign busy = (state == SETTLE) | (state == CHECK);
    assign done = (state == DONE);
    assign pass = done & (err_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            vec              <= '0;
            waitCnt          <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state            <= nextState;
            vec              <= vecNext;
            waitCnt          <= waitCntNext;
            err_count        <= errCountNext;
            first_fail_vec   <= firstFailVecNext;
            first_fail_valid <= firstFailValidNext;
        end
    end

    always_comb begin
        nextState          = state;
        vecNext            = vec;
        waitCntNext        = waitCnt;
        errCountNext       = err_count;
        firstFailVecNext   = first_fail_vec;
        firstFailValidNext = first_fail_valid;

        case (state)
            // DONE accepts a restart exactly like IDLE, wiping old results
            IDLE, DONE: begin
                if (start) begin
                    nextState          = SETTLE;
                    vecNext            = '0;
                    waitCntNext        = '0;
                    errCountNext       = '0;
                    firstFailVecNext   = '0;
                    firstFailValidNext = 1'b0;
                end
            end
            SETTLE: begin
                waitCntNext = waitCnt + CNT_W'(1);
                if (waitCnt == LAST_WAIT) begin
                    nextState = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_count != ERR_MAX) begin
                        errCountNext = err_count + ERR_W'(1);
                    end
                    if (!first_fail_valid) begin
                        firstFailVecNext   = vec;
                        firstFailValidNext = 1'b1;
                    end
                end
                if (vec == LAST_VEC) begin
                    nextState = DONE;
                end else begin
                    vecNext     = vec + VEC_W'(1);
                    waitCntNext = '0;
                    nextState   = SETTLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lab1_gate_tester.sv
// Scoreboard bench for lab1_gate_tester: expected run results are queued at
// start and popped by per-DUT monitors on the rising edge of done.
module tb_lab1_gate_tester;

    typedef struct {
        int errCnt;
        int ffVec;
        int ffValid;
        int passV;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passCnt = 0;
    int checkCnt = 0;

    exp_t q2[$];
    exp_t q1[$];

    // DUT with SETTLE_CYCLES=2 and a fault-injectable gate model
    logic       reset2, start2;
    logic       inAND2, inOR2, inNOT2;
    logic       outA2, outB2, busy2, done2, pass2, ffValid2;
    logic [2:0] err2;
    logic [1:0] ffVec2;
    int         fault = 0;

    assign inAND2 = outA2 & outB2;
    assign inOR2  = (fault == 1) ? 1'b0 : (outA2 | outB2);
    assign inNOT2 = (fault == 2) ? outA2 : ~outA2;

    lab1_gate_tester #(.SETTLE_CYCLES(2), .ERR_W(3)) dut2 (
        .clk(clk), .reset(reset2), .start(start2),
        .inAND(inAND2), .inOR(inOR2), .inNOT(inNOT2),
        .outA(outA2), .outB(outB2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail_vec(ffVec2), .first_fail_valid(ffValid2)
    );

    // DUT with SETTLE_CYCLES=1 and an ideal gate model
    logic       reset1, start1;
    logic       outA1, outB1, busy1, done1, pass1, ffValid1;
    logic [2:0] err1;
    logic [1:0] ffVec1;

    lab1_gate_tester #(.SETTLE_CYCLES(1), .ERR_W(3)) dut1 (
        .clk(clk), .reset(reset1), .start(start1),
        .inAND(outA1 & outB1), .inOR(outA1 | outB1), .inNOT(~outA1),
        .outA(outA1), .outB(outB1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_vec(ffVec1), .first_fail_valid(ffValid1)
    );

    task automatic check(input string name, input int act, input int exp);
        checkCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor for dut2
    logic busy2Prev = 1'b0, done2Prev = 1'b0;
    int   rise2 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (busy2 && !busy2Prev) rise2 = cyc;
        if (done2 && !done2Prev) begin
            if (q2.size() == 0) begin
                check("dut2_unexpected_done", 1, 0);
            end else begin
                e = q2.pop_front();
                check("dut2_err_count", int'(err2), e.errCnt);
                check("dut2_first_fail_vec", int'(ffVec2), e.ffVec);
                check("dut2_first_fail_valid", int'(ffValid2), e.ffValid);
                check("dut2_pass", int'(pass2), e.passV);
                check("dut2_latency", cyc - rise2, e.lat);
            end
        end
        busy2Prev = busy2;
        done2Prev = done2;
    end

    // Monitor for dut1
    logic busy1Prev = 1'b0, done1Prev = 1'b0;
    int   rise1 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (busy1 && !busy1Prev) rise1 = cyc;
        if (done1 && !done1Prev) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_done", 1, 0);
            end else begin
                e = q1.pop_front();
                check("dut1_err_count", int'(err1), e.errCnt);
                check("dut1_first_fail_vec", int'(ffVec1), e.ffVec);
                check("dut1_first_fail_valid", int'(ffValid1), e.ffValid);
                check("dut1_pass", int'(pass1), e.passV);
                check("dut1_latency", cyc - rise1, e.lat);
            end
        end
        busy1Prev = busy1;
        done1Prev = done1;
    end

    task automatic waitDone2(input int bound);
        int n = 0;
        while (!done2 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!done2) check("dut2_done_timeout", 0, 1);
    endtask

    task automatic waitDone1(input int bound);
        int n = 0;
        while (!done1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!done1) check("dut1_done_timeout", 0, 1);
    endtask

    task automatic checkAllZero2(input string tag);
        check({tag, "_outA"}, int'(outA2), 0);
        check({tag, "_outB"}, int'(outB2), 0);
        check({tag, "_busy"}, int'(busy2), 0);
        check({tag, "_done"}, int'(done2), 0);
        check({tag, "_pass"}, int'(pass2), 0);
        check({tag, "_err_count"}, int'(err2), 0);
        check({tag, "_first_fail_vec"}, int'(ffVec2), 0);
        check({tag, "_first_fail_valid"}, int'(ffValid2), 0);
    endtask

    task automatic pulseStart2();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    initial begin
        int seq[8];
        int n;
        seq = '{0, 0, 1, 1, 2, 2, 3, 3};
        reset2 = 1'b1; start2 = 1'b0;
        reset1 = 1'b1; start1 = 1'b0;
        repeat (2) @(negedge clk);
        reset2 = 1'b0; reset1 = 1'b0;
        checkAllZero2("reset");

        // Ideal gates: clean pass, results hold in DONE
        fault = 0;
        q2.push_back('{0, 0, 0, 1, 12});
        pulseStart2();
        check("ideal_busy_after_start", int'(busy2), 1);
        waitDone2(40);
        repeat (3) @(negedge clk);
        check("ideal_done_holds", int'(done2), 1);
        check("ideal_pass_holds", int'(pass2), 1);
        check("ideal_done_outAB", int'({outA2, outB2}), 3);

        // OR stuck at 0
        fault = 1;
        q2.push_back('{3, 1, 1, 0, 12});
        pulseStart2();
        waitDone2(40);
        @(negedge clk);

        // NOT inverted, start held into DONE then restart clears results
        fault = 2;
        q2.push_back('{4, 0, 1, 0, 12});
        start2 = 1'b1;
        @(negedge clk);
        waitDone2(40);
        fault = 0;
        q2.push_back('{0, 0, 0, 1, 12});
        @(negedge clk);
        check("restart_busy", int'(busy2), 1);
        check("restart_done_low", int'(done2), 0);
        check("restart_err_cleared", int'(err2), 0);
        check("restart_ffvalid_cleared", int'(ffValid2), 0);
        check("restart_outAB", int'({outA2, outB2}), 0);
        start2 = 1'b0;
        waitDone2(40);
        @(negedge clk);

        // Reset during the third vector's SETTLE, with start also high
        fault = 1;
        pulseStart2();
        n = 0;
        while (!(busy2 && outA2 && !outB2) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach_vec2", int'(busy2 && outA2 && !outB2), 1);
        reset2 = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        reset2 = 1'b0;
        start2 = 1'b0;
        checkAllZero2("midrun_reset");
        @(negedge clk);
        check("idle_after_reset_busy", int'(busy2), 0);
        fault = 0;
        q2.push_back('{0, 0, 0, 1, 12});
        pulseStart2();
        waitDone2(40);

        // SETTLE_CYCLES=1: stimulus sequence cycle by cycle
        q1.push_back('{0, 0, 0, 1, 8});
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("s1_seq%0d", i), int'({outA1, outB1}), seq[i]);
            check($sformatf("s1_busy%0d", i), int'(busy1), 1);
            @(negedge clk);
        end
        waitDone1(20);

        repeat (3) @(negedge clk);
        check("q2_drained", q2.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
